param_not_pipe: RTL and testbench

PARAM_NOT_PIPE -- requirements
Module: param_not_pipe

---
 rtl/param_not_pipe.sv | 106 ++++++++++
 tb/tb_param_not_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/param_not_pipe.sv
// param_not_pipe: elastic STAGES-deep pipeline that passes, inverts or mask-inverts each word.
// Sticky error on illegal mode, wrapping delivered-transaction counter.
`default_nettype none
`timescale 1ns/1ps

module param_not_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic              run_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              deliver;
  logic [WIDTH-1:0]  result;
  logic              full_above;

  always_comb begin
    result = ~in_data;
    case (in_mode)
      2'b00:   result = in_data;
      2'b01:   result = ~in_data;
      2'b10:   result = in_data ^ in_mask;
      default: result = ~in_data;
    endcase
  end

  // A stage moves forward if any later stage is empty (the gap closes) or the
  // whole tail is full and the output is being consumed.
  always_comb begin
    adv        = '0;
    full_above = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]     = valid_q[k] & (out_ready | ~full_above);
      full_above = full_above & valid_q[k];
    end
  end

  assign in_ready = run_q & (~valid_q[0] | adv[0]);
  assign accept   = in_valid & in_ready;
  assign deliver  = valid_q[STAGES-1] & out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = result;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    err_d = err_q | (accept & (in_mode == 2'b11));
    cnt_d = deliver ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // run_q keeps in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign err       = err_q;
  assign txn_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_param_not_pipe.sv
// tb_param_not_pipe: directed checks of param_not_pipe (WIDTH=8, STAGES=2), plus a CNT_W=4 copy for counter wrap.
`default_nettype none
`timescale 1ns/1ps

module tb_param_not_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic [7:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        err;
  logic [15:0] txn_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic        err4;
  logic [3:0]  txn_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_not_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .txn_cnt(txn_cnt)
  );

  param_not_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_mask(in_mask),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .err(err4), .txn_cnt(txn_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_mask  = k;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_txn_cnt", txn_cnt, 16'd0);
    tick();
    chk("rst_hold_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_before_edge_in_ready", in_ready, 1'b0);
    tick();
    chk("rel_after_edge_in_ready", in_ready, 1'b1);

    // Basic pass/invert and latency
    drive(1'b1, 8'h00, 2'b01, 8'h00);
    tick();
    chk("lat_no_early_valid", out_valid, 1'b0);
    drive(1'b1, 8'hA5, 2'b00, 8'h00);
    tick();
    chk("inv_valid", out_valid, 1'b1);
    chk("inv_data", out_data, 8'hFF);
    chk("inv_data_cnt4", out_data4, 8'hFF);
    drive(1'b0, 8'h00, 2'b11, 8'h00);
    tick();
    chk("pass_data", out_data, 8'hA5);
    chk("pass_valid", out_valid, 1'b1);
    tick();
    chk("idle_valid", out_valid, 1'b0);
    chk("cnt_after_two", txn_cnt, 16'd2);
    chk("err_ignored_idle_mode", err, 1'b0);

    // Masked invert
    drive(1'b1, 8'hF0, 2'b10, 8'h3C);
    tick();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    tick();
    chk("mask_data", out_data, 8'hCC);
    chk("mask_err", err, 1'b0);
    tick();
    chk("cnt_after_mask", txn_cnt, 16'd3);

    // Back-pressure: only two words fit
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'b00, 8'h00);
    tick();
    drive(1'b1, 8'h22, 2'b00, 8'h00);
    tick();
    drive(1'b1, 8'h33, 2'b00, 8'h00);
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_out_data", out_data, 8'h11);
    tick();
    chk("bp_frozen_data", out_data, 8'h11);
    chk("bp_still_not_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk("bp_word2", out_data, 8'h22);
    drive(1'b1, 8'h44, 2'b00, 8'h00);
    tick();
    chk("bp_word3", out_data, 8'h33);
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    tick();
    chk("bp_word4", out_data, 8'h44);
    tick();
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_cnt", txn_cnt, 16'd7);

    // Illegal mode: sticky error, word still inverted
    drive(1'b1, 8'h0F, 2'b11, 8'h00);
    tick();
    chk("ill_err_set", err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 2'b00, 8'hFF);
      tick();
      if (i == 0) chk("ill_data", out_data, 8'hF0);
    end
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    tick();
    chk("ill_tail_data", out_data, 8'h09);
    chk("cnt17_main", txn_cnt, 16'd17);
    chk("cnt17_wrap4", txn_cnt4, 4'd1);
    tick();
    chk("ill_err_sticky", err, 1'b1);
    chk("cnt18_wrap4", txn_cnt4, 4'd2);

    // Reset mid-stream with a full pipe
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 2'b00, 8'h00);
    tick();
    drive(1'b1, 8'hBB, 2'b00, 8'h00);
    tick();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    chk("pre_rst_full", out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_cnt", txn_cnt, 16'd0);
    chk("async_rst_err", err, 1'b0);
    chk("async_rst_data", out_data, 8'h00);
    chk("async_rst_in_ready", in_ready, 1'b0);
    tick();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h5A, 2'b00, 8'h00);
    chk("rel2_in_ready_low", in_ready, 1'b0);
    tick();
    chk("rel2_no_stale", out_valid, 1'b0);
    chk("rel2_in_ready_high", in_ready, 1'b1);
    tick();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    chk("rel2_lat", out_valid, 1'b0);
    tick();
    chk("rel2_first_valid", out_valid, 1'b1);
    chk("rel2_first_data", out_data, 8'h5A);
    chk("rel2_err", err, 1'b0);
    tick();
    chk("rel2_cnt", txn_cnt, 16'd1);
    chk("rel2_drained", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
